cve2_obi_mem_adapter: RTL and testbench

CVE2_OBI_MEM_ADAPTER -- requirements
Module: cve2_obi_mem_adapter

---
 rtl/cve2_obi_mem_adapter.sv | 114 +++++++++++
 tb/tb_cve2_obi_mem_adapter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cve2_obi_mem_adapter.sv
// OBI slave adapter that maps one address window onto a single-port SRAM with a
// one-cycle read latency, optional grant wait states and error responses for misses.
module cve2_obi_mem_adapter #(
   parameter logic [31:0] BaseAddr   = 32'h0000_0000,
   parameter int unsigned AddrWidth  = 16,
   parameter int unsigned WaitStates = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_i,
   output logic                 gnt_o,
   output logic                 rvalid_o,
   input  logic                 we_i,
   input  logic [3:0]           be_i,
   input  logic [31:0]          addr_i,
   input  logic [31:0]          wdata_i,
   output logic [31:0]          rdata_o,
   output logic                 err_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [3:0]           mem_be_o,
   output logic [AddrWidth-3:0] mem_addr_o,
   output logic [31:0]          mem_wdata_o,
   input  logic [31:0]          mem_rdata_i
);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_e;

   localparam logic [2:0] WaitInit = (WaitStates > 0) ? 3'(WaitStates - 1) : 3'd0;

   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       rvalid_q, rvalid_d;
   logic       err_q, err_d;
   logic       rd_q, rd_d;
   logic       gnt;
   logic       in_range;
   logic       unused_addr_lsb;

   assign in_range        = (addr_i[31:AddrWidth] == BaseAddr[31:AddrWidth]);
   assign unused_addr_lsb = ^addr_i[1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               if (WaitStates == 0) begin
                  gnt = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WaitInit;
               end
            end
         end
         S_WAIT: begin
            // A retracted request abandons the wait without granting.
            if (!req_i) begin
               state_d = S_IDLE;
               cnt_d   = 3'd0;
            end else if (cnt_q == 3'd0) begin
               gnt     = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // The grant is combinational from req_i, so it is masked while reset is held.
   assign gnt_o = gnt & rst_ni;

   assign rvalid_d = gnt_o;
   assign err_d    = gnt_o & ~in_range;
   assign rd_d     = gnt_o & ~we_i & in_range;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         cnt_q    <= 3'd0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rd_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rd_q     <= rd_d;
      end
   end

   assign mem_req_o   = gnt_o & in_range;
   assign mem_we_o    = we_i;
   assign mem_be_o    = be_i;
   assign mem_addr_o  = addr_i[AddrWidth-1:2];
   assign mem_wdata_o = wdata_i;

   // Response payload comes from flags captured at grant, not from the live request.
   assign rvalid_o = rvalid_q;
   assign err_o    = rvalid_q & err_q;
   assign rdata_o  = (rvalid_q & rd_q) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_cve2_obi_mem_adapter.sv
// Bench for cve2_obi_mem_adapter: a zero-wait instance and a three-wait-state instance
// at a non-zero base, each backed by a behavioural SRAM and checked against a byte-level memory model.
module tb_cve2_obi_mem_adapter;

   localparam logic [31:0] BASE0 = 32'h0000_0000;
   localparam int unsigned AW0   = 16;
   localparam logic [31:0] BASE3 = 32'h0002_0000;
   localparam int unsigned AW3   = 12;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   logic        req0 = 0, we0 = 0, gnt0, rvalid0, err0, mreq0, mwe0;
   logic [3:0]  be0 = 0, mbe0;
   logic [31:0] addr0 = 0, wdata0 = 0, rdata0, mwdata0, mrdata0;
   logic [13:0] maddr0;

   logic        req3 = 0, we3 = 0, gnt3, rvalid3, err3, mreq3, mwe3;
   logic [3:0]  be3 = 0, mbe3;
   logic [31:0] addr3 = 0, wdata3 = 0, rdata3, mwdata3, mrdata3;
   logic [9:0]  maddr3;

   int checks = 0;
   int failures = 0;

   cve2_obi_mem_adapter #(.BaseAddr(BASE0), .AddrWidth(AW0), .WaitStates(0)) dut0 (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req0), .gnt_o(gnt0), .rvalid_o(rvalid0),
      .we_i(we0), .be_i(be0), .addr_i(addr0), .wdata_i(wdata0), .rdata_o(rdata0), .err_o(err0),
      .mem_req_o(mreq0), .mem_we_o(mwe0), .mem_be_o(mbe0), .mem_addr_o(maddr0),
      .mem_wdata_o(mwdata0), .mem_rdata_i(mrdata0));

   cve2_obi_mem_adapter #(.BaseAddr(BASE3), .AddrWidth(AW3), .WaitStates(3)) dut3 (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req3), .gnt_o(gnt3), .rvalid_o(rvalid3),
      .we_i(we3), .be_i(be3), .addr_i(addr3), .wdata_i(wdata3), .rdata_o(rdata3), .err_o(err3),
      .mem_req_o(mreq3), .mem_we_o(mwe3), .mem_be_o(mbe3), .mem_addr_o(maddr3),
      .mem_wdata_o(mwdata3), .mem_rdata_i(mrdata3));

   // Behavioural SRAMs with one-cycle read latency.
   logic [31:0] sram0 [0:16383];
   logic [31:0] sram3 [0:1023];

   always @(posedge clk_i) begin
      if (mreq0) begin
         if (mwe0) begin
            for (int b = 0; b < 4; b++)
               if (mbe0[b]) sram0[maddr0][8*b +: 8] <= mwdata0[8*b +: 8];
         end else begin
            mrdata0 <= sram0[maddr0];
         end
      end
   end

   always @(posedge clk_i) begin
      if (mreq3) begin
         if (mwe3) begin
            for (int b = 0; b < 4; b++)
               if (mbe3[b]) sram3[maddr3][8*b +: 8] <= mwdata3[8*b +: 8];
         end else begin
            mrdata3 <= sram3[maddr3];
         end
      end
   end

   // Reference model: byte-addressed memory per instance, unwritten bytes read as zero.
   byte unsigned model0 [int unsigned];
   byte unsigned model3 [int unsigned];

   function automatic bit model_in_range(input int d, input logic [31:0] a);
      if (d == 0) return (a >> AW0) == (BASE0 >> AW0);
      return (a >> AW3) == (BASE3 >> AW3);
   endfunction

   function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
      logic [31:0] w;
      int unsigned base;
      w = 32'h0;
      base = int'(a) & ~32'd3;
      for (int b = 0; b < 4; b++) begin
         if (d == 0 && model0.exists(base + b)) w[8*b +: 8] = model0[base + b];
         if (d == 3 && model3.exists(base + b)) w[8*b +: 8] = model3[base + b];
      end
      return w;
   endfunction

   function automatic void model_write(input int d, input logic [31:0] a, input logic [3:0] be,
                                       input logic [31:0] wd);
      int unsigned base;
      base = int'(a) & ~32'd3;
      for (int b = 0; b < 4; b++) begin
         if (be[b] && d == 0) model0[base + b] = wd[8*b +: 8];
         if (be[b] && d == 3) model3[base + b] = wd[8*b +: 8];
      end
   endfunction

   // Expected response of a granted transaction, applying its effect to the model.
   function automatic void model_access(input int d, input logic we, input logic [31:0] a,
                                        input logic [3:0] be, input logic [31:0] wd,
                                        output logic [31:0] exp_rdata, output logic exp_err);
      exp_rdata = 32'h0;
      exp_err   = 1'b0;
      if (!model_in_range(d, a)) begin
         exp_err = 1'b1;
      end else if (we) begin
         model_write(d, a, be, wd);
      end else begin
         exp_rdata = model_read(d, a);
      end
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      req0 = 1; we0 = 0; addr0 = 32'h10; be0 = 4'hF;
      req3 = 1; we3 = 0; addr3 = BASE3 + 32'h10; be3 = 4'hF;
      @(negedge clk_i);
      checks++; if (gnt0 !== 1'b0) begin failures++; $display("FAIL reset_gnt0 got=%b exp=0", gnt0); end
      checks++; if (rvalid0 !== 1'b0) begin failures++; $display("FAIL reset_rvalid0 got=%b exp=0", rvalid0); end
      checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL reset_err0 got=%b exp=0", err0); end
      checks++; if (rdata0 !== 32'h0) begin failures++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
      checks++; if (mreq0 !== 1'b0) begin failures++; $display("FAIL reset_mreq0 got=%b exp=0", mreq0); end
      checks++; if (gnt3 !== 1'b0) begin failures++; $display("FAIL reset_gnt3 got=%b exp=0", gnt3); end
      checks++; if (rvalid3 !== 1'b0) begin failures++; $display("FAIL reset_rvalid3 got=%b exp=0", rvalid3); end
      checks++; if (mreq3 !== 1'b0) begin failures++; $display("FAIL reset_mreq3 got=%b exp=0", mreq3); end
      tick();
      req0 = 0; req3 = 0;
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_write_read();
      logic [31:0] er;
      logic ee;
      req0 = 1; we0 = 1; addr0 = 32'h10; be0 = 4'hF; wdata0 = 32'hDEAD_BEEF;
      @(negedge clk_i);
      checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL wr_gnt got=%b exp=1", gnt0); end
      checks++; if (mreq0 !== 1'b1) begin failures++; $display("FAIL wr_mreq got=%b exp=1", mreq0); end
      checks++; if (maddr0 !== 14'h4) begin failures++; $display("FAIL wr_maddr got=%h exp=4", maddr0); end
      checks++; if (mwe0 !== 1'b1 || mbe0 !== 4'hF || mwdata0 !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL wr_payload got=%b/%h/%h exp=1/f/deadbeef", mwe0, mbe0, mwdata0); end
      model_access(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, er, ee);
      tick();
      we0 = 0; wdata0 = 32'h0;
      @(negedge clk_i);
      checks++; if (rvalid0 !== 1'b1 || err0 !== 1'b0 || rdata0 !== 32'h0) begin
         failures++; $display("FAIL wr_resp got=%b/%b/%h exp=1/0/0", rvalid0, err0, rdata0); end
      checks++; if (gnt0 !== 1'b1 || maddr0 !== 14'h4 || mwe0 !== 1'b0) begin
         failures++; $display("FAIL rd_req got=%b/%h/%b exp=1/4/0", gnt0, maddr0, mwe0); end
      model_access(0, 1'b0, 32'h10, 4'hF, 32'h0, er, ee);
      tick();
      req0 = 0;
      @(negedge clk_i);
      checks++; if (rvalid0 !== 1'b1 || err0 !== ee || rdata0 !== er) begin
         failures++; $display("FAIL rd_resp got=%b/%b/%h exp=1/%b/%h", rvalid0, err0, rdata0, ee, er); end
      tick();
      @(negedge clk_i);
      checks++; if (rvalid0 !== 1'b0 || rdata0 !== 32'h0) begin
         failures++; $display("FAIL idle_after_rd got=%b/%h exp=0/0", rvalid0, rdata0); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] er, pend_rdata;
      logic ee, pend_err;
      for (int i = 0; i < 7; i++) begin
         if (i < 6) begin
            req0 = 1; we0 = (i < 3); addr0 = 32'(4 * (i % 3)); be0 = 4'hF; wdata0 = $urandom;
         end else begin
            req0 = 0;
         end
         @(negedge clk_i);
         checks++; if (gnt0 !== (i < 6)) begin failures++; $display("FAIL b2b_gnt%0d got=%b exp=%b", i, gnt0, i < 6); end
         if (i > 0) begin
            checks++; if (rvalid0 !== 1'b1 || rdata0 !== pend_rdata || err0 !== pend_err) begin
               failures++; $display("FAIL b2b_resp%0d got=%b/%h/%b exp=1/%h/%b", i, rvalid0, rdata0, err0, pend_rdata, pend_err); end
         end
         if (i < 6) begin
            model_access(0, we0, addr0, be0, wdata0, er, ee);
            pend_rdata = er; pend_err = ee;
         end
         tick();
      end
      req0 = 0;
   endtask

   task automatic test_out_of_range();
      for (int k = 0; k < 2; k++) begin
         req0 = 1; we0 = (k == 1); addr0 = (k == 0) ? 32'h0001_0000 : 32'h8000_0104;
         be0 = 4'hF; wdata0 = 32'h1234_5678;
         @(negedge clk_i);
         checks++; if (gnt0 !== 1'b1 || mreq0 !== 1'b0) begin
            failures++; $display("FAIL oor_req%0d gnt/mreq got=%b/%b exp=1/0", k, gnt0, mreq0); end
         tick();
         req0 = 0;
         @(negedge clk_i);
         checks++; if (rvalid0 !== 1'b1 || err0 !== 1'b1 || rdata0 !== 32'h0) begin
            failures++; $display("FAIL oor_resp%0d got=%b/%b/%h exp=1/1/0", k, rvalid0, err0, rdata0); end
         tick();
      end
   endtask

   task automatic test_wait_states();
      logic [31:0] er;
      logic ee;
      logic [31:0] wd;
      wd = $urandom;
      // Held write then held read: grant on the fourth request cycle, response one later.
      for (int t = 0; t < 2; t++) begin
         req3 = 1; we3 = (t == 0); addr3 = BASE3 + 32'h40; be3 = 4'hF; wdata3 = wd;
         for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            checks++; if (gnt3 !== (c == 3) || mreq3 !== (c == 3)) begin
               failures++; $display("FAIL ws_gnt t%0d c%0d got=%b/%b exp=%b", t, c, gnt3, mreq3, c == 3); end
            checks++; if (rvalid3 !== (c == 4)) begin
               failures++; $display("FAIL ws_rvalid t%0d c%0d got=%b exp=%b", t, c, rvalid3, c == 4); end
            if (c == 3) model_access(3, we3, addr3, be3, wdata3, er, ee);
            if (c == 4) begin
               checks++; if (rdata3 !== er || err3 !== ee) begin
                  failures++; $display("FAIL ws_data t%0d got=%h/%b exp=%h/%b", t, rdata3, err3, er, ee); end
            end
            tick();
            if (c == 3) req3 = 0;
         end
      end
      // Retracted request: no grant, no response, and a fresh request waits the full count.
      req3 = 1; we3 = 0;
      tick();
      tick();
      req3 = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         checks++; if (gnt3 !== 1'b0 || rvalid3 !== 1'b0 || mreq3 !== 1'b0) begin
            failures++; $display("FAIL ws_drop c%0d got=%b/%b/%b exp=0/0/0", c, gnt3, rvalid3, mreq3); end
         tick();
      end
      req3 = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         checks++; if (gnt3 !== (c == 3)) begin
            failures++; $display("FAIL ws_after_drop c%0d got=%b exp=%b", c, gnt3, c == 3); end
         tick();
      end
      req3 = 0;
      tick();
   endtask

   task automatic test_random0();
      logic [31:0] er, pend_rdata;
      logic ee, pend_err, pend_valid;
      int n_gnt, n_rvalid;
      pend_valid = 0; pend_rdata = 0; pend_err = 0;
      n_gnt = 0; n_rvalid = 0;
      for (int i = 0; i < 301; i++) begin
         req0 = (i < 300) && ($urandom_range(0, 9) < 7);
         we0 = $urandom_range(0, 1);
         be0 = 4'($urandom);
         wdata0 = $urandom;
         if ($urandom_range(0, 3) == 0) addr0 = $urandom | 32'h0001_0000;
         else addr0 = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
         @(negedge clk_i);
         if (gnt0 === 1'b1) n_gnt++;
         if (rvalid0 === 1'b1) n_rvalid++;
         checks++; if (gnt0 !== req0) begin failures++; $display("FAIL rnd0_gnt%0d got=%b exp=%b", i, gnt0, req0); end
         checks++; if (rvalid0 !== pend_valid || rdata0 !== pend_rdata || err0 !== pend_err) begin
            failures++; $display("FAIL rnd0_resp%0d got=%b/%h/%b exp=%b/%h/%b", i, rvalid0, rdata0, err0, pend_valid, pend_rdata, pend_err); end
         checks++; if (mreq0 !== (req0 && model_in_range(0, addr0))) begin
            failures++; $display("FAIL rnd0_mreq%0d got=%b exp=%b", i, mreq0, req0 && model_in_range(0, addr0)); end
         if (req0 && model_in_range(0, addr0)) begin
            checks++; if (maddr0 !== addr0[15:2] || mwe0 !== we0) begin
               failures++; $display("FAIL rnd0_maddr%0d got=%h/%b exp=%h/%b", i, maddr0, mwe0, addr0[15:2], we0); end
         end
         if (req0) begin
            model_access(0, we0, addr0, be0, wdata0, er, ee);
            $display("txn dut0 %0d we=%b addr=%h be=%h wdata=%h -> rdata=%h err=%b", i, we0, addr0, be0, wdata0, er, ee);
            pend_valid = 1; pend_rdata = er; pend_err = ee;
         end else begin
            pend_valid = 0; pend_rdata = 0; pend_err = 0;
         end
         tick();
      end
      req0 = 0;
      checks++; if (n_gnt != n_rvalid) begin failures++; $display("FAIL rnd0_counts got=%0d exp=%0d", n_rvalid, n_gnt); end
   endtask

   task automatic test_random3();
      logic [31:0] er;
      logic ee;
      int lat;
      for (int t = 0; t < 20; t++) begin
         req3 = 1; we3 = $urandom_range(0, 1); be3 = 4'($urandom); wdata3 = $urandom;
         addr3 = BASE3 + 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) addr3 = addr3 | 32'h0000_1000;
         lat = -1;
         for (int c = 0; c < 10 && lat < 0; c++) begin
            @(negedge clk_i);
            checks++; if (mreq3 !== (gnt3 && model_in_range(3, addr3))) begin
               failures++; $display("FAIL rnd3_mreq t%0d c%0d got=%b", t, c, mreq3); end
            if (gnt3 === 1'b1) lat = c;
            tick();
         end
         checks++; if (lat != 3) begin failures++; $display("FAIL rnd3_latency t%0d got=%0d exp=3", t, lat); end
         model_access(3, we3, addr3, be3, wdata3, er, ee);
         $display("txn dut3 %0d we=%b addr=%h be=%h wdata=%h -> rdata=%h err=%b", t, we3, addr3, be3, wdata3, er, ee);
         req3 = 0;
         @(negedge clk_i);
         checks++; if (rvalid3 !== 1'b1 || rdata3 !== er || err3 !== ee) begin
            failures++; $display("FAIL rnd3_resp t%0d got=%b/%h/%b exp=1/%h/%b", t, rvalid3, rdata3, err3, er, ee); end
         tick();
      end
   endtask

   task automatic test_reset_pending();
      req0 = 1; we0 = 0; addr0 = 32'h10; be0 = 4'hF;
      @(negedge clk_i);
      checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL rstp_gnt got=%b exp=1", gnt0); end
      tick();
      req0 = 0;
      rst_ni = 1'b0;
      #1;
      checks++; if (rvalid0 !== 1'b0 || err0 !== 1'b0 || rdata0 !== 32'h0) begin
         failures++; $display("FAIL rstp_drop got=%b/%b/%h exp=0/0/0", rvalid0, err0, rdata0); end
      tick();
      rst_ni = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         checks++; if (rvalid0 !== 1'b0 || gnt0 !== 1'b0 || mreq0 !== 1'b0 || rvalid3 !== 1'b0) begin
            failures++; $display("FAIL rstp_idle c%0d got=%b/%b/%b/%b exp=0/0/0/0", c, rvalid0, gnt0, mreq0, rvalid3); end
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) sram0[i] = 32'h0;
      for (int i = 0; i < 1024; i++) sram3[i] = 32'h0;
      mrdata0 = 32'h0;
      mrdata3 = 32'h0;
      tick();
      test_reset();
      test_write_read();
      test_back_to_back();
      test_out_of_range();
      test_wait_states();
      test_random0();
      test_random3();
      test_reset_pending();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
